// File: rtl/eth_wb_pkg.sv
// rtl/eth_wb_pkg.sv - register map, FSM encoding and status bits for the Ethernet TX framer
package eth_wb_pkg;

  localparam logic [9:0] OFF_CTRL     = 10'h000;
  localparam logic [9:0] OFF_LEN      = 10'h004;
  localparam logic [9:0] OFF_DST_LO   = 10'h008;
  localparam logic [9:0] OFF_DST_HI   = 10'h00C;
  localparam logic [9:0] OFF_SRC_LO   = 10'h010;
  localparam logic [9:0] OFF_SRC_HI   = 10'h014;
  localparam logic [9:0] OFF_ETYPE    = 10'h018;
  localparam logic [9:0] OFF_ERR_LO   = 10'h020;
  localparam logic [9:0] OFF_BUF_BASE = 10'h100;

  localparam int ETH_HDR_LEN = 14;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IRQ_EN  = 2;
  localparam int STAT_OVR     = 3;
  localparam int STAT_LEN_ERR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/eth_tx_buf.sv
// rtl/eth_tx_buf.sv - payload buffer: simple dual-port RAM, byte-enabled write, registered read
module eth_tx_buf #(
  parameter int BUF_WORDS = 64,
  parameter int AW        = $clog2(BUF_WORDS)
) (
  input  logic          clk_mac,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [BUF_WORDS];

  always_ff @(posedge clk_mac) begin
    for (int k = 0; k < 4; k++) begin
      if (we && be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_tx_framer_wb.sv
// rtl/eth_tx_framer_wb.sv - Wishbone-programmed Ethernet TX frame builder streaming bytes to eth_mac
module eth_tx_framer_wb
  import eth_wb_pkg::*;
#(
  parameter int BUF_WORDS = 64,
  parameter bit PAD_EN    = 1'b1,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk_mac,
  input  logic        cpu_rst_n,
  input  logic [31:0] wb_eth_adr_i,
  input  logic [31:0] wb_eth_dat_i,
  input  logic [3:0]  wb_eth_sel_i,
  input  logic        wb_eth_we_i,
  input  logic        wb_eth_stb_i,
  input  logic        wb_eth_cyc_i,
  input  logic [2:0]  wb_eth_cti_i,
  input  logic [1:0]  wb_eth_bte_i,
  output logic [31:0] wb_eth_dat_o,
  output logic        wb_eth_ack_o,
  output logic        wb_eth_err_o,
  output logic        wb_eth_rty_o,
  output logic [7:0]  tx_axis_mac_tdata,
  output logic        tx_axis_mac_tvalid,
  output logic        tx_axis_mac_tlast,
  input  logic        tx_axis_mac_tready,
  output logic        tx_irq
);

  localparam int MAX_PL = 4 * BUF_WORDS;
  localparam int AW     = $clog2(BUF_WORDS);

  tx_state_t   state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] eff_len_q, len_q, dst_hi_q, src_hi_q, etype_q, frames_q;
  logic [31:0] dst_lo_q, src_lo_q, csr_rdata_q, csr_rdata, ram_q;
  logic        done_q, ovr_q, len_err_q, irq_en_q, rd_buf_q;
  logic [9:0]  offset;
  logic [7:0]  buf_word, hdr_byte;
  logic [15:0] hdr_pl, frame_len;
  logic [1:0]  pl_lane;
  logic [AW-1:0] rd_addr;
  logic        req, in_buf, unmapped, err_cond, wr_ack, busy, start_ok, beat, last;
  logic        unused_ok;

  assign offset   = {wb_eth_adr_i[9:2], 2'b00};
  assign buf_word = wb_eth_adr_i[9:2] - 8'h40;
  assign in_buf   = (wb_eth_adr_i[9:8] != 2'b00) && (32'(buf_word) < 32'(BUF_WORDS));
  assign unmapped = (offset >= OFF_ERR_LO) && (offset < OFF_BUF_BASE);
  assign req      = wb_eth_cyc_i & wb_eth_stb_i;
  assign busy     = (state_q != ST_IDLE);
  assign err_cond = (wb_eth_we_i & in_buf & busy) | unmapped;
  assign wr_ack   = wb_eth_ack_o & req & wb_eth_we_i;
  assign start_ok = wr_ack && (offset == OFF_CTRL) && wb_eth_dat_i[CTRL_START] && !busy;
  assign wb_eth_rty_o = 1'b0;
  assign tx_irq       = done_q & irq_en_q;
  assign unused_ok    = &{1'b0, wb_eth_adr_i[31:10], wb_eth_adr_i[1:0], wb_eth_cti_i, wb_eth_bte_i};

  assign hdr_pl    = 16'(ETH_HDR_LEN) + eff_len_q;
  assign frame_len = (PAD_EN && hdr_pl < 16'(MIN_FRAME)) ? 16'(MIN_FRAME) : hdr_pl;
  assign last      = (byte_cnt_q == frame_len - 16'd1);
  assign beat      = tx_axis_mac_tvalid & tx_axis_mac_tready;
  assign pl_lane   = 2'(byte_cnt_q - 16'(ETH_HDR_LEN));

  // Read address follows the next byte position so the word is ready when that byte is due;
  // the streamer owns the read port while payload is flowing.
  assign rd_addr = (state_d == ST_PAYLOAD) ? AW'((byte_cnt_d - 16'(ETH_HDR_LEN)) >> 2)
                                           : AW'(buf_word);

  eth_tx_buf #(.BUF_WORDS(BUF_WORDS)) u_buf (
    .clk_mac (clk_mac),
    .we      (wr_ack & in_buf),
    .be      (wb_eth_sel_i),
    .waddr   (AW'(buf_word)),
    .wdata   (wb_eth_dat_i),
    .raddr   (rd_addr),
    .rdata   (ram_q)
  );

  always_comb begin
    csr_rdata = 32'd0;
    case (offset)
      OFF_CTRL:   csr_rdata = {frames_q, 11'd0, len_err_q, ovr_q, irq_en_q, done_q, busy};
      OFF_LEN:    csr_rdata = {16'd0, len_q};
      OFF_DST_LO: csr_rdata = dst_lo_q;
      OFF_DST_HI: csr_rdata = {16'd0, dst_hi_q};
      OFF_SRC_LO: csr_rdata = src_lo_q;
      OFF_SRC_HI: csr_rdata = {16'd0, src_hi_q};
      OFF_ETYPE:  csr_rdata = {16'd0, etype_q};
      default:    csr_rdata = 32'd0;
    endcase
  end

  assign wb_eth_dat_o = rd_buf_q ? ram_q : csr_rdata_q;

  always_ff @(posedge clk_mac or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      wb_eth_ack_o <= 1'b0;
      wb_eth_err_o <= 1'b0;
      csr_rdata_q  <= 32'd0;
      rd_buf_q     <= 1'b0;
      len_q        <= 16'd0;
      eff_len_q    <= 16'd0;
      dst_lo_q     <= 32'd0;
      dst_hi_q     <= 16'd0;
      src_lo_q     <= 32'd0;
      src_hi_q     <= 16'd0;
      etype_q      <= 16'd0;
      frames_q     <= 16'd0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      len_err_q    <= 1'b0;
      irq_en_q     <= 1'b0;
    end else begin
      wb_eth_ack_o <= req & ~wb_eth_ack_o & ~err_cond;
      wb_eth_err_o <= req & ~wb_eth_err_o & err_cond;
      if (req && !wb_eth_ack_o) begin
        csr_rdata_q <= csr_rdata;
        rd_buf_q    <= in_buf;
      end
      if (wr_ack) begin
        case (offset)
          OFF_CTRL: begin
            irq_en_q <= wb_eth_dat_i[CTRL_IRQ_EN];
            if (wb_eth_dat_i[CTRL_CLR_DONE]) begin
              done_q    <= 1'b0;
              ovr_q     <= 1'b0;
              len_err_q <= 1'b0;
            end
            // Later assignments win, so a combined CLR_DONE+START clears first, then starts.
            if (wb_eth_dat_i[CTRL_START]) begin
              if (busy) begin
                ovr_q <= 1'b1;
              end else begin
                eff_len_q <= (len_q > 16'(MAX_PL)) ? 16'(MAX_PL) : len_q;
                len_err_q <= (len_q > 16'(MAX_PL));
              end
            end
          end
          OFF_LEN:    len_q    <= wb_eth_dat_i[15:0];
          OFF_DST_LO: dst_lo_q <= wb_eth_dat_i;
          OFF_DST_HI: dst_hi_q <= wb_eth_dat_i[15:0];
          OFF_SRC_LO: src_lo_q <= wb_eth_dat_i;
          OFF_SRC_HI: src_hi_q <= wb_eth_dat_i[15:0];
          OFF_ETYPE:  etype_q  <= wb_eth_dat_i[15:0];
          default: ;
        endcase
      end
      if (state_q == ST_DONE) begin
        done_q   <= 1'b1;
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_mac or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_HDR;
          byte_cnt_d = 16'd0;
        end
      end
      ST_HDR, ST_PAYLOAD, ST_PAD: begin
        if (beat) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (last)
            state_d = ST_DONE;
          else if (state_q == ST_HDR && byte_cnt_q == 16'(ETH_HDR_LEN - 1))
            state_d = (eff_len_q != 16'd0) ? ST_PAYLOAD : ST_PAD;
          else if (state_q == ST_PAYLOAD && byte_cnt_q == hdr_pl - 16'd1)
            state_d = ST_PAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_byte = 8'd0;
    case (byte_cnt_q[3:0])
      4'd0:  hdr_byte = dst_hi_q[15:8];
      4'd1:  hdr_byte = dst_hi_q[7:0];
      4'd2:  hdr_byte = dst_lo_q[31:24];
      4'd3:  hdr_byte = dst_lo_q[23:16];
      4'd4:  hdr_byte = dst_lo_q[15:8];
      4'd5:  hdr_byte = dst_lo_q[7:0];
      4'd6:  hdr_byte = src_hi_q[15:8];
      4'd7:  hdr_byte = src_hi_q[7:0];
      4'd8:  hdr_byte = src_lo_q[31:24];
      4'd9:  hdr_byte = src_lo_q[23:16];
      4'd10: hdr_byte = src_lo_q[15:8];
      4'd11: hdr_byte = src_lo_q[7:0];
      4'd12: hdr_byte = etype_q[15:8];
      4'd13: hdr_byte = etype_q[7:0];
      default: hdr_byte = 8'd0;
    endcase
  end

  always_comb begin
    tx_axis_mac_tvalid = 1'b0;
    tx_axis_mac_tdata  = 8'd0;
    case (state_q)
      ST_HDR: begin
        tx_axis_mac_tvalid = 1'b1;
        tx_axis_mac_tdata  = hdr_byte;
      end
      ST_PAYLOAD: begin
        tx_axis_mac_tvalid = 1'b1;
        tx_axis_mac_tdata  = ram_q[8*pl_lane +: 8];
      end
      ST_PAD:  tx_axis_mac_tvalid = 1'b1;
      default: ;
    endcase
  end

  assign tx_axis_mac_tlast = tx_axis_mac_tvalid & last;

endmodule

// File: doc/eth_tx_framer_wb.md
Name: eth_tx_framer_wb

Overview:
- Wishbone-programmable Ethernet TX frame builder. Next generation of the fixed-packet transmitter.
- Software writes the destination MAC, source MAC, EtherType, payload length and payload bytes, then issues a start command.
- The block streams header, payload and optional zero padding as a byte-wide AXI-Stream into the eth_mac tx_axis_mac_* interface.
- It sits in the clk_mac domain, between the CPU Wishbone bus and eth_mac.

Parameters:
- BUF_WORDS, 64: payload buffer depth in 32-bit words; maximum payload MAX_PL = 4*BUF_WORDS bytes; power of two.
- PAD_EN, 1: 1 pads frames shorter than MIN_FRAME with 0x00 bytes; 0 sends the exact length.
- MIN_FRAME, 60: minimum frame length in bytes, excluding FCS.

Ports:
- clk_mac  in  1  MAC clock; all logic on its rising edge.
- cpu_rst_n  in  1  asynchronous, active-high reset. The name follows the existing module; polarity is high.
- wb_eth_adr_i  in  32  byte address; bits [9:2] decoded.
- wb_eth_dat_i  in  32  write data.
- wb_eth_sel_i  in  4  byte enables; honoured for buffer writes only.
- wb_eth_we_i  in  1  write strobe.
- wb_eth_stb_i  in  1  strobe.
- wb_eth_cyc_i  in  1  cycle.
- wb_eth_cti_i  in  3  ignored; classic cycles only.
- wb_eth_bte_i  in  2  ignored.
- wb_eth_dat_o  out  32  read data.
- wb_eth_ack_o  out  1  acknowledge.
- wb_eth_err_o  out  1  error response.
- wb_eth_rty_o  out  1  tied 0.
- tx_axis_mac_tdata  out  8  frame byte.
- tx_axis_mac_tvalid  out  1  byte valid.
- tx_axis_mac_tlast  out  1  last byte of frame.
- tx_axis_mac_tready  in  1  MAC accepts byte.
- tx_irq  out  1  level; high while DONE is set and IRQ_EN=1.

Behaviour:

Wishbone handshake:
- ack_o <= cyc&stb&~ack_o&~err_cond.
- err_o <= cyc&stb&~err_o&err_cond.
- Every access completes in exactly 1 wait state; no back-to-back ack.
- err_cond: write to the payload window while BUSY, or access to an unmapped offset in [0x020,0x0FF].
- Register side effects occur in the ack cycle.

Register map (word offsets from base):
- 0x00 CTRL/STATUS.
  - Write: bit0 START, bit1 CLR_DONE, bit2 IRQ_EN.
  - Read: bit0 BUSY, bit1 DONE, bit2 IRQ_EN, bit3 OVR, bit4 LEN_ERR, [31:16] frames-sent counter (wraps at 0xFFFF).
- 0x04 LEN [15:0]: payload bytes.
- 0x08 DST_LO: MAC bytes 2..5, with byte 5 in [7:0].
- 0x0C DST_HI [15:0]: MAC bytes 0..1, with byte 0 in [15:8].
- 0x10 SRC_LO, 0x14 SRC_HI: same layout as DST.
- 0x18 ETYPE [15:0]: sent MSB first.
- 0x100 + 4*i: payload word i, i < BUF_WORDS.
  - Byte 4i+k is taken from dat[8k+7:8k] (little-endian within the word).
  - Reads return buffer contents.

Reset values:
- All registers 0; counter 0; state IDLE.
- tvalid=0, tlast=0, tdata=0, ack_o=0, err_o=0, tx_irq=0.
- Buffer contents are undefined.
- Reset asserted mid-frame drops tvalid immediately (asynchronous); the frame is truncated without tlast.

FSM states: IDLE, HDR, PAYLOAD, PAD, DONE.
- IDLE: START accepted with BUSY=0 -> capture eff_len = min(LEN, MAX_PL); set LEN_ERR if LEN > MAX_PL; go to HDR.
  - Byte 0 is presented with tvalid=1 on the cycle after the ack.
- HDR: 14 bytes in order DST0..5, SRC0..5, ETYPE[15:8], ETYPE[7:0].
  - Advance only on tvalid&tready; tdata/tvalid stay stable while tready=0.
- PAYLOAD: eth_len bytes from the buffer.
  - Buffer read is prefetched so that consecutive bytes issue on back-to-back cycles when tready stays high.
- PAD: entered if PAD_EN and 14+eff_len < MIN_FRAME; emits 0x00 bytes until the total reaches MIN_FRAME.
- tlast is high on exactly the final byte, whether header, payload or pad.
- eff_len=0: header only, plus padding if PAD_EN.
- DONE: one cycle; set DONE, increment the counter, return to IDLE.
- START while BUSY: ignored; sets OVR.
- START and CLR_DONE in the same write: DONE is cleared, then the frame starts.
- DONE, OVR and LEN_ERR are sticky; CLR_DONE clears all three.

Decomposition:
- Package eth_wb_pkg holds:
  - register offsets (CTRL, LEN, DST_LO/HI, SRC_LO/HI, ETYPE, BUF_BASE);
  - FSM state encoding;
  - ETH_HDR_LEN=14;
  - status bit indices.
- Sub-module eth_tx_buf: single-clock simple dual-port RAM, BUF_WORDS x 32.
  - Write port has byte enables; read port has 1-cycle registered latency.
  - Infers BRAM or distributed RAM.

Test Plan:
1. DST=FF:FF:FF:FF:FF:FF, SRC=00:0A:35:01:02:03, ETYPE=0xEBEB, LEN=5, payload "Dato ", tready=1, PAD_EN=1 -> 60 bytes; bytes 14..18 = 44 61 74 6F 20, bytes 19..59 = 00, tlast only on byte 59, DONE=1, counter=1.
2. LEN=100, tready toggling 1/0 every cycle -> 114 bytes, no byte dropped or duplicated, tdata stable during stall, no padding.
3. START written twice while BUSY -> second START ignored, OVR=1, exactly one frame with tlast.
4. LEN=0x1000 with BUF_WORDS=64 -> LEN_ERR=1, frame = 14+256 bytes; LEN=0 with PAD_EN=0 -> 14 bytes, tlast on ETYPE LSB.
5. Payload write during BUSY -> err_o pulses for 1 cycle, no ack, buffer unchanged; byte-lane write with sel=4'b0100 changes only byte 4i+2.
6. cpu_rst_n pulsed high at byte 30 of a frame -> tvalid=0 in the same cycle, STATUS reads 0; the next START sends a full, correct frame.
